// File: rtl/xilly_loopback_fifo.sv
// xilly_loopback_fifo: parametrised Xillybus host-write to host-read loopback
// buffer with fill level, saturating overflow count and end-of-file reporting.
// Optional feature macro: LOOPBACK_SUM_EN (store a running sum of written
// words, restarted on each rising edge of user_w_open).
module xilly_loopback_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              quiesce,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  input  logic              user_w_open,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic [AW:0]       fill_level,
  output logic [15:0]       overflow_cnt
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_EOF} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_ovf;
  logic              r_eof;
  state_t            r_state;

  logic              w_flush;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_drop;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] w_wdata;
  state_t            w_state_nxt;

  assign w_flush  = quiesce || (!user_w_open && !user_r_open);
  assign w_wr_acc = user_w_wren && !r_full && !w_flush;
  assign w_rd_acc = user_r_rden && !r_empty && !w_flush;
  assign w_drop   = user_w_wren && r_full && !w_flush;

`ifdef LOOPBACK_SUM_EN
  logic              r_w_open_q;
  logic [DATA_W-1:0] r_sum;
  logic              w_open_rise;
  logic [DATA_W-1:0] w_sum_base;

  assign w_open_rise = user_w_open && !r_w_open_q;
  assign w_sum_base  = w_open_rise ? '0 : r_sum;
  assign w_wdata     = w_sum_base + user_w_data;

  // Running-sum accumulator, restarted by a fresh open of the write file
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_w_open_q <= 1'b0;
      r_sum      <= '0;
    end else begin
      r_w_open_q <= user_w_open;
      if (w_wr_acc)
        r_sum <= w_wdata;
      else if (w_open_rise)
        r_sum <= '0;
    end
  end
`else
  assign w_wdata = user_w_data;
`endif

  // Occupancy after this cycle's accepted read/write or flush
  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)
      w_count_nxt = '0;
    else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Storage array; no reset so it maps onto RAM
  always_ff @(posedge bus_clk) begin
    if (w_wr_acc)
      r_mem[r_wptr] <= w_wdata;
  end

  // Pointers, count, flags and read data
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= '0;
    end else begin
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_acc)
          r_wptr <= r_wptr + AW'(1);
        if (w_rd_acc) begin
          r_rptr <= r_rptr + AW'(1);
          r_data <= r_mem[r_rptr];
        end
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Saturating count of writes refused because the buffer was full
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)
      r_ovf <= '0;
    else if (w_drop && (r_ovf != 16'hFFFF))
      r_ovf <= r_ovf + 16'd1;
  end

  // EOF state register and its delayed indication
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_state <= S_IDLE;
      r_eof   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_eof   <= (r_state == S_EOF);
    end
  end

  // EOF next-state logic; quiesce overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (quiesce)
      w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (user_w_open) w_state_nxt = S_STREAM;
        S_STREAM: if (!user_w_open) w_state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (user_w_open)
            w_state_nxt = S_STREAM;
          else if (w_count_nxt == '0)
            w_state_nxt = S_EOF;
        end
        S_EOF: begin
          if (user_w_open)
            w_state_nxt = S_STREAM;
          else if (!user_r_open)
            w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign user_w_full  = r_full;
  assign user_r_empty = r_empty;
  assign user_r_data  = r_data;
  assign user_r_eof   = r_eof;
  assign fill_level   = r_count;
  assign overflow_cnt = r_ovf;

endmodule
